axi_read_arbiter: RTL

AXI_READ_ARBITER -- requirements
Module: axi_read_arbiter

---
 rtl/axi_read_arbiter_if.sv | 53 +++++
 rtl/axi_read_arbiter.sv | 112 +++++++++++
 2 files changed

// File: rtl/axi_read_arbiter_if.sv
// Signal bundle between the two cache requesters, the read arbiter and the
// AXI read channels (AR + R). The master modport is the arbiter's view; the
// slave modport is the view of whatever surrounds it (caches + memory).
interface axi_read_arbiter_if #(
    parameter int LINE_BEATS = 4,
    parameter int ADDR_W     = 32
);
    localparam int BEAT_W = $clog2(LINE_BEATS);

    // Requester side
    logic              i_rreq;
    logic [ADDR_W-1:0] i_raddr;
    logic              d_rreq;
    logic [ADDR_W-1:0] d_raddr;
    logic              i_rvalid;
    logic              d_rvalid;
    logic [31:0]       c_rdata;
    logic              c_rlast;
    logic [BEAT_W-1:0] c_beat;

    // AXI read address channel
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;

    // AXI read data channel
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;
    logic              rlast;

    modport master (
        input  i_rreq, i_raddr, d_rreq, d_raddr,
        output i_rvalid, d_rvalid, c_rdata, c_rlast, c_beat,
        output araddr, arvalid, arlen, arsize, arburst,
        input  arready,
        input  rdata, rresp, rvalid, rlast,
        output rready
    );

    modport slave (
        output i_rreq, i_raddr, d_rreq, d_raddr,
        input  i_rvalid, d_rvalid, c_rdata, c_rlast, c_beat,
        input  araddr, arvalid, arlen, arsize, arburst,
        output arready,
        output rdata, rresp, rvalid, rlast,
        input  rready
    );
endinterface

// File: rtl/axi_read_arbiter.sv
// Round-robin arbiter that shares one AXI read port between an icache and a
// dcache line-fill engine. One cache-line INCR burst is in flight at a time;
// the returning beats are steered to whichever cache won the grant.
module axi_read_arbiter #(
    parameter int LINE_BEATS = 4,
    parameter int ADDR_W     = 32
) (
    input logic                clk,
    input logic                rstn,
    axi_read_arbiter_if.master bus
);
    localparam int BEAT_W = $clog2(LINE_BEATS);
    // Byte offset bits inside one line (4-byte beats).
    localparam int OFFS_W = $clog2(LINE_BEATS * 4);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AR   = 2'd1,
        R    = 2'd2
    } state_t;

    state_t            state_q;
    logic              gnt_dcache_q;   // 1: current burst belongs to the dcache
    logic              last_dcache_q;  // 1: most recently completed burst was dcache
    logic [ADDR_W-1:0] araddr_q;
    logic              arvalid_q;
    logic              rready_q;
    logic [BEAT_W-1:0] beat_q;

    logic              pick_dcache_d;
    logic [ADDR_W-1:0] line_addr_d;

    // rresp carries no information this block acts on.
    logic unused_rresp;
    assign unused_rresp = ^bus.rresp;

    // Round-robin choice among the current requesters and the winner's line address
    always_comb begin
        pick_dcache_d = bus.d_rreq;
        if (bus.i_rreq && bus.d_rreq) begin
            pick_dcache_d = ~last_dcache_q;
        end
        line_addr_d = pick_dcache_d ? bus.d_raddr : bus.i_raddr;
        line_addr_d[OFFS_W-1:0] = '0;
    end

    // Burst sequencing: grant in IDLE, address handshake in AR, beat return in R
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= IDLE;
            gnt_dcache_q  <= 1'b0;
            last_dcache_q <= 1'b0;   // icache counted as last, so a first tie goes to dcache
            araddr_q      <= '0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            beat_q        <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // Requests are only looked at here; anything raised later waits.
                    if (bus.i_rreq || bus.d_rreq) begin
                        gnt_dcache_q <= pick_dcache_d;
                        araddr_q     <= line_addr_d;
                        arvalid_q    <= 1'b1;
                        state_q      <= AR;
                    end
                end
                AR: begin
                    // araddr_q is not touched until the slave takes it.
                    if (bus.arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        beat_q    <= '0;
                        state_q   <= R;
                    end
                end
                R: begin
                    if (bus.rvalid) begin
                        // Power-of-two LINE_BEATS makes the natural overflow the wrap.
                        beat_q <= beat_q + 1'b1;
                        // rlast alone ends the burst, whatever the beat count says.
                        if (bus.rlast) begin
                            rready_q      <= 1'b0;
                            last_dcache_q <= gnt_dcache_q;
                            state_q       <= IDLE;
                        end
                    end
                end
                default: begin
                    arvalid_q <= 1'b0;
                    rready_q  <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    // AR channel: registered handshake, fixed burst shape
    assign bus.arvalid = arvalid_q;
    assign bus.araddr  = araddr_q;
    assign bus.arlen   = 8'(LINE_BEATS - 1);
    assign bus.arsize  = 3'b010;
    assign bus.arburst = 2'b01;

    // R channel: rready_q is high exactly while in R, so it also gates forwarding
    assign bus.rready   = rready_q;
    assign bus.c_rdata  = bus.rdata;
    assign bus.c_rlast  = rready_q & bus.rlast;
    assign bus.c_beat   = beat_q;
    assign bus.i_rvalid = rready_q & bus.rvalid & ~gnt_dcache_q;
    assign bus.d_rvalid = rready_q & bus.rvalid &  gnt_dcache_q;
endmodule
